// File: rtl/led_frame_buffer_if.sv
// led_frame_buffer_if
//   Groups every non-clock, non-reset signal of led_frame_buffer into one bundle.
//   - master: driven by the display driver and the writer (CPU/DMA).
//   - slave:  the frame buffer itself.
//
//   Signal groups:
//   - Read ports:    pixelAddress0/1 -> pixel0/1. These read the front bank,
//                    top and bottom half respectively.
//   - Frame timing:  displayDone, a one-cycle end-of-frame pulse.
//   - Write port:    wrAddr/wrData/wrValid -> wrReady. This writes the back bank.
//   - Control:       swapRequest and clearRequest/clearValue.
//   - Status:        swapPending, clearing, frontBuffer, frameCount.
interface led_frame_buffer_if #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int HALF_ADDR_WIDTH = 11
);
  logic [HALF_ADDR_WIDTH-1:0] pixelAddress0;
  logic [PIXEL_WIDTH-1:0]     pixel0;
  logic [HALF_ADDR_WIDTH-1:0] pixelAddress1;
  logic [PIXEL_WIDTH-1:0]     pixel1;
  logic                       displayDone;
  logic [HALF_ADDR_WIDTH:0]   wrAddr;
  logic [PIXEL_WIDTH-1:0]     wrData;
  logic                       wrValid;
  logic                       wrReady;
  logic                       swapRequest;
  logic                       clearRequest;
  logic [PIXEL_WIDTH-1:0]     clearValue;
  logic                       swapPending;
  logic                       clearing;
  logic                       frontBuffer;
  logic [7:0]                 frameCount;

  modport master (
    output pixelAddress0, pixelAddress1, displayDone,
    output wrAddr, wrData, wrValid, swapRequest, clearRequest, clearValue,
    input  pixel0, pixel1, wrReady, swapPending, clearing, frontBuffer, frameCount
  );

  modport slave (
    input  pixelAddress0, pixelAddress1, displayDone,
    input  wrAddr, wrData, wrValid, swapRequest, clearRequest, clearValue,
    output pixel0, pixel1, wrReady, swapPending, clearing, frontBuffer, frameCount
  );
endinterface

// File: rtl/led_frame_buffer.sv
// led_frame_buffer
//   Double-buffered pixel store feeding the LED matrix driver. The driver
//   reads the front bank, and the writer fills or clears the back bank.
//   Swaps are committed only on the driver's end-of-frame pulse, so a frame
//   never tears.
//
//   Ports:
//   - clk: system clock.
//   - rst: asynchronous, active-low reset.
//   - bus: led_frame_buffer_if.slave. This carries the read ports, the write
//          port, and the control and status signals.
//
//   FSM states:
//   state        | meaning
//   -------------+--------------------------------------------------
//   ST_IDLE      | accepts writes; samples clear/swap requests
//   ST_CLEARING  | fills both halves of the back bank, one address per cycle
//   ST_SWAP_WAIT | swap accepted; waits for displayDone to commit it
module led_frame_buffer #(
  parameter int PIXEL_WIDTH     = 8,
  parameter int HALF_ADDR_WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst,
  led_frame_buffer_if.slave  bus
);

  localparam int DEPTH = 2 ** HALF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CLEARING  = 2'd1,
    ST_SWAP_WAIT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       front_q, front_d;
  logic [7:0]                 count_q, count_d;
  logic [HALF_ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [PIXEL_WIDTH-1:0]     clr_val_q, clr_val_d;
  logic [PIXEL_WIDTH-1:0]     pixel0_q, pixel1_q;

  // Index layout: {bank, pixel address}. One array per half, so that a clear
  // can write both halves in the same cycle.
  logic [PIXEL_WIDTH-1:0]     mem_top [0:2*DEPTH-1];
  logic [PIXEL_WIDTH-1:0]     mem_bot [0:2*DEPTH-1];

  logic                       top_we, bot_we;
  logic [HALF_ADDR_WIDTH:0]   wr_idx;
  logic [PIXEL_WIDTH-1:0]     wr_data;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    count_d   = count_q;
    clr_cnt_d = clr_cnt_q;
    clr_val_d = clr_val_q;
    top_we    = 1'b0;
    bot_we    = 1'b0;
    wr_idx    = {~front_q, bus.wrAddr[HALF_ADDR_WIDTH-1:0]};
    wr_data   = bus.wrData;

    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as an accepted request still commits.
        if (bus.wrValid) begin
          top_we = ~bus.wrAddr[HALF_ADDR_WIDTH];
          bot_we = bus.wrAddr[HALF_ADDR_WIDTH];
        end
        if (bus.clearRequest) begin
          clr_val_d = bus.clearValue;
          clr_cnt_d = '0;
          state_d   = ST_CLEARING;
        end else if (bus.swapRequest) begin
          state_d = ST_SWAP_WAIT;
        end
      end

      ST_CLEARING: begin
        top_we    = 1'b1;
        bot_we    = 1'b1;
        wr_idx    = {~front_q, clr_cnt_q};
        wr_data   = clr_val_q;
        clr_cnt_d = clr_cnt_q + HALF_ADDR_WIDTH'(1);
        if (clr_cnt_q == {HALF_ADDR_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end

      ST_SWAP_WAIT: begin
        if (bus.displayDone) begin
          front_d = ~front_q;
          count_d = count_q + 8'd1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      front_q   <= 1'b0;
      count_q   <= 8'd0;
      clr_cnt_q <= '0;
      clr_val_q <= '0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      count_q   <= count_d;
      clr_cnt_q <= clr_cnt_d;
      clr_val_q <= clr_val_d;
    end
  end

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (top_we) mem_top[wr_idx] <= wr_data;
    if (bot_we) mem_bot[wr_idx] <= wr_data;
  end

  // Writes only ever target the back bank, so these reads never collide with a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel0_q <= '0;
      pixel1_q <= '0;
    end else begin
      pixel0_q <= mem_top[{front_q, bus.pixelAddress0}];
      pixel1_q <= mem_bot[{front_q, bus.pixelAddress1}];
    end
  end

  assign bus.pixel0      = pixel0_q;
  assign bus.pixel1      = pixel1_q;
  assign bus.wrReady     = (state_q == ST_IDLE);
  assign bus.clearing    = (state_q == ST_CLEARING);
  assign bus.swapPending = (state_q == ST_SWAP_WAIT);
  assign bus.frontBuffer = front_q;
  assign bus.frameCount  = count_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
module tb_led_frame_buffer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  led_frame_buffer_if #(.PIXEL_WIDTH(8), .HALF_ADDR_WIDTH(11)) bus ();

  led_frame_buffer #(.PIXEL_WIDTH(8), .HALF_ADDR_WIDTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.pixelAddress0 = '0;
    bus.pixelAddress1 = '0;
    bus.displayDone   = 1'b0;
    bus.wrAddr        = '0;
    bus.wrData        = '0;
    bus.wrValid       = 1'b0;
    bus.swapRequest   = 1'b0;
    bus.clearRequest  = 1'b0;
    bus.clearValue    = '0;

    // Reset state.
    tick(); tick();
    chk("rst_pixel0", 32'(bus.pixel0), 32'h0);
    chk("rst_pixel1", 32'(bus.pixel1), 32'h0);
    rst = 1'b1;
    tick();
    chk("rst_front",    32'(bus.frontBuffer), 32'd0);
    chk("rst_count",    32'(bus.frameCount),  32'd0);
    chk("rst_wrready",  32'(bus.wrReady),     32'd1);
    chk("rst_pending",  32'(bus.swapPending), 32'd0);
    chk("rst_clearing", 32'(bus.clearing),    32'd0);

    // displayDone while idle does nothing.
    bus.displayDone = 1'b1; tick(); bus.displayDone = 1'b0; tick();
    chk("idle_done_front", 32'(bus.frontBuffer), 32'd0);
    chk("idle_done_count", 32'(bus.frameCount),  32'd0);

    // Write then swap.
    bus.wrValid = 1'b1; bus.wrAddr = 12'h005; bus.wrData = 8'h15; tick();
    bus.wrAddr = 12'h805; bus.wrData = 8'h2A; tick();
    bus.wrValid = 1'b0;
    bus.swapRequest = 1'b1; tick(); bus.swapRequest = 1'b0;
    chk("swap_pending", 32'(bus.swapPending), 32'd1);
    chk("swap_wrready", 32'(bus.wrReady),     32'd0);
    tick(); tick();
    bus.displayDone = 1'b1; tick(); bus.displayDone = 1'b0;
    chk("swap1_front",   32'(bus.frontBuffer), 32'd1);
    chk("swap1_count",   32'(bus.frameCount),  32'd1);
    chk("swap1_pending", 32'(bus.swapPending), 32'd0);
    bus.pixelAddress0 = 11'd5; bus.pixelAddress1 = 11'd5; tick();
    chk("swap1_pixel0", 32'(bus.pixel0), 32'h15);
    chk("swap1_pixel1", 32'(bus.pixel1), 32'h2A);

    // Swap gating: a done pulse in the accepting cycle is ignored.
    bus.wrValid = 1'b1; bus.wrAddr = 12'h007; bus.wrData = 8'h11; tick();
    bus.wrAddr = 12'h807; bus.wrData = 8'h22; tick();
    bus.wrValid = 1'b0;
    bus.swapRequest = 1'b1; bus.displayDone = 1'b1; tick();
    bus.swapRequest = 1'b0; bus.displayDone = 1'b0;
    chk("gate_pending", 32'(bus.swapPending), 32'd1);
    chk("gate_front",   32'(bus.frontBuffer), 32'd1);
    bus.wrValid = 1'b1; bus.wrAddr = 12'h007; bus.wrData = 8'hEE; tick();
    chk("gate_wrready", 32'(bus.wrReady), 32'd0);
    bus.wrAddr = 12'h807; tick();
    bus.wrValid = 1'b0;
    bus.displayDone = 1'b1; tick(); bus.displayDone = 1'b0;
    chk("gate_front2", 32'(bus.frontBuffer), 32'd0);
    chk("gate_count2", 32'(bus.frameCount),  32'd2);
    bus.pixelAddress0 = 11'd7; bus.pixelAddress1 = 11'd7; tick();
    chk("gate_pixel0", 32'(bus.pixel0), 32'h11);
    chk("gate_pixel1", 32'(bus.pixel1), 32'h22);

    // Clear the back bank (bank 1).
    bus.clearRequest = 1'b1; bus.clearValue = 8'h3F; tick();
    bus.clearRequest = 1'b0; bus.clearValue = 8'h00;
    chk("clr_clearing", 32'(bus.clearing), 32'd1);
    chk("clr_wrready",  32'(bus.wrReady),  32'd0);
    cyc = 0;
    while (bus.clearing && cyc < 3000) begin
      tick();
      cyc++;
    end
    chk("clr_cycles",   32'(cyc),          32'd2048);
    chk("clr_wrready2", 32'(bus.wrReady),  32'd1);
    tick();
    chk("clr_old_front_p0", 32'(bus.pixel0), 32'h11);
    chk("clr_old_front_p1", 32'(bus.pixel1), 32'h22);
    bus.swapRequest = 1'b1; tick(); bus.swapRequest = 1'b0;
    bus.displayDone = 1'b1; tick(); bus.displayDone = 1'b0;
    chk("clr_swap_front", 32'(bus.frontBuffer), 32'd1);
    chk("clr_swap_count", 32'(bus.frameCount),  32'd3);
    for (int a = 0; a < 2048; a++) begin
      bus.pixelAddress0 = 11'(a);
      bus.pixelAddress1 = 11'(a);
      tick();
      chk("clr_fill_top", 32'(bus.pixel0), 32'h3F);
      chk("clr_fill_bot", 32'(bus.pixel1), 32'h3F);
    end

    // Priority: the clear wins over a simultaneous swap.
    bus.clearRequest = 1'b1; bus.swapRequest = 1'b1; bus.clearValue = 8'h00; tick();
    bus.clearRequest = 1'b0; bus.swapRequest = 1'b0;
    chk("prio_clearing", 32'(bus.clearing),    32'd1);
    chk("prio_pending",  32'(bus.swapPending), 32'd0);
    for (int i = 0; i < 999; i++) tick();
    chk("prio_still_clearing", 32'(bus.clearing), 32'd1);

    // Reset mid-clear takes effect immediately.
    rst = 1'b0;
    #1;
    chk("mid_rst_clearing", 32'(bus.clearing),    32'd0);
    chk("mid_rst_pending",  32'(bus.swapPending), 32'd0);
    chk("mid_rst_wrready",  32'(bus.wrReady),     32'd1);
    chk("mid_rst_front",    32'(bus.frontBuffer), 32'd0);
    chk("mid_rst_count",    32'(bus.frameCount),  32'd0);
    chk("mid_rst_pixel0",   32'(bus.pixel0),      32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Commit 256 swaps: the frame counter wraps to 0.
    for (int s = 0; s < 256; s++) begin
      bus.swapRequest = 1'b1; tick(); bus.swapRequest = 1'b0;
      bus.displayDone = 1'b1; tick(); bus.displayDone = 1'b0;
      if (s == 254) begin
        chk("wrap_count_255", 32'(bus.frameCount),  32'd255);
        chk("wrap_front_255", 32'(bus.frontBuffer), 32'd1);
      end
    end
    chk("wrap_count", 32'(bus.frameCount),  32'd0);
    chk("wrap_front", 32'(bus.frontBuffer), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
